// File: rtl/rv32_pkg.sv
// rv32_pkg: shared core constants and write-port arbiter state encoding.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_STALL} arb_state_e;
endpackage

// File: rtl/wport_fifo.sv
// wport_fifo: circular FIFO of {rd, data} with a per-register pending mask.
module wport_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [4:0]      push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count,
  output logic [4:0]      head_rd,
  output logic [XLEN-1:0] head_data,
  output logic [31:0]     pending_mask
);
  logic [4:0]      rd_q [DEPTH];
  logic [4:0]      rd_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    vld_d   = vld_q;
    head_d  = pop ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop) vld_d[head_q] = 1'b0;
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      rd_d[tail_q]   = push_rd;
      data_d[tail_q] = push_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '{default: '0};
      data_q  <= '{default: '0};
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      pending_mask = pending_mask | (vld_q[i] ? 32'(1) << rd_q[i] : 32'(0));
  end
  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;
  assign count     = count_q;
  assign head_rd   = rd_q[head_q];
  assign head_data = data_q[head_q];
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the RF write port between write-back and queued MDU results,
// with a starvation stall so queued results always retire.
module rf_wport_arbiter import rv32_pkg::*; #(
  parameter int XLEN     = rv32_pkg::XLEN,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int WW = $clog2(MAX_WAIT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            mdu_grant,
  output logic            stall_req,
  output logic [31:0]     pending_mask
);
  arb_state_e      state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            full, empty, push, wb_act, drain;
  logic [CW-1:0]   count;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic [31:0]     fifo_mask;
  wport_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_rd      (mdu_rd),
    .push_data    (mdu_data),
    .pop          (mdu_grant),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .pending_mask (fifo_mask)
  );
  // x0 results are acknowledged but never stored
  assign mdu_ready    = !rst && !full;
  assign push         = mdu_valid && mdu_ready && mdu_rd != REG_X0;
  assign wb_act       = !rst && wb_we && wb_rd != REG_X0;
  assign mdu_grant    = !rst && !wb_act && !empty;
  assign rf_we        = wb_act || mdu_grant;
  assign rf_waddr     = wb_act ? wb_rd : mdu_grant ? head_rd : '0;
  assign rf_wdata     = wb_act ? wb_data : mdu_grant ? head_data : '0;
  assign pending_mask = rst ? '0 : fifo_mask;
  assign drain        = count == CW'(1) && !push;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ARB_IDLE: state_d = push ? ARB_WAIT : ARB_IDLE;
      ARB_WAIT: begin
        wcnt_d  = mdu_grant ? '0 : wcnt_q + WW'(1);
        state_d = mdu_grant ? (drain ? ARB_IDLE : ARB_WAIT)
                : wcnt_q + WW'(1) == WW'(MAX_WAIT) ? ARB_STALL : ARB_WAIT;
      end
      ARB_STALL: begin
        wcnt_d  = mdu_grant ? '0 : wcnt_q;
        state_d = mdu_grant ? (drain ? ARB_IDLE : ARB_WAIT) : ARB_STALL;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_comb stall_req = state_q == ARB_STALL;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed vectors with hand-computed expectations for rf_wport_arbiter.
module tb_rf_wport_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mdu_grant;
  logic        stall_req;
  logic [31:0] pending_mask;
  int vectors = 0;
  int miscompares = 0;
  rf_wport_arbiter #(.XLEN(32), .DEPTH(2), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .mdu_grant    (mdu_grant),
    .stall_req    (stall_req),
    .pending_mask (pending_mask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d, input logic g);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".rf_wdata"}, rf_wdata, d);
    chk({tag, ".mdu_grant"}, 32'(mdu_grant), 32'(g));
  endtask
  task automatic cyc(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md);
    @(posedge clk);
    #1;
    wb_we = wv; wb_rd = wr; wb_data = wd;
    mdu_valid = mv; mdu_rd = mr; mdu_data = md;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst.ready", 32'(mdu_ready), 0);
    chk("rst.stall", 32'(stall_req), 0);
    chk("rst.mask", pending_mask, 0);
    port("rst", 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    // idle drain
    cyc(0, 0, 0, 1, 5, 32'h12345678);
    chk("drain.ready", 32'(mdu_ready), 1);
    port("drain.t", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    port("drain.t1", 1, 5, 32'h12345678, 1);
    chk("drain.mask1", pending_mask, 32'h20);
    cyc(0, 0, 0, 0, 0, 0);
    port("drain.t2", 0, 0, 0, 0);
    chk("drain.mask2", pending_mask, 0);
    // priority, full, starvation
    cyc(1, 3, 32'hAAAA, 1, 7, 32'h70);
    port("prio.b0", 1, 3, 32'hAAAA, 0);
    cyc(1, 3, 32'hAAAA, 1, 9, 32'h90);
    port("prio.b1", 1, 3, 32'hAAAA, 0);
    chk("prio.mask1", pending_mask, 32'h80);
    chk("prio.ready1", 32'(mdu_ready), 1);
    cyc(1, 3, 32'hAAAA, 0, 0, 0);
    port("prio.b2", 1, 3, 32'hAAAA, 0);
    chk("full.ready", 32'(mdu_ready), 0);
    chk("full.mask", pending_mask, 32'h280);
    chk("starve.b2", 32'(stall_req), 0);
    cyc(1, 3, 32'hAAAA, 0, 0, 0);
    cyc(1, 3, 32'hAAAA, 0, 0, 0);
    chk("starve.b4", 32'(stall_req), 0);
    cyc(1, 3, 32'hAAAA, 0, 0, 0);
    chk("starve.b5", 32'(stall_req), 1);
    port("starve.b5", 1, 3, 32'hAAAA, 0);
    cyc(0, 0, 0, 0, 0, 0);
    port("starve.b6", 1, 7, 32'h70, 1);
    chk("starve.hold", 32'(stall_req), 1);
    cyc(1, 3, 32'hBBBB, 0, 0, 0);
    chk("starve.release", 32'(stall_req), 0);
    chk("starve.mask", pending_mask, 32'h200);
    port("starve.b7", 1, 3, 32'hBBBB, 0);
    cyc(1, 3, 32'hBBBB, 0, 0, 0);
    cyc(1, 3, 32'hBBBB, 1, 4, 32'h40);
    chk("restart.b9", 32'(stall_req), 0);
    cyc(1, 3, 32'hBBBB, 0, 0, 0);
    chk("restart.b11", 32'(stall_req), 0);
    cyc(1, 3, 32'hBBBB, 0, 0, 0);
    chk("restart.stall", 32'(stall_req), 1);
    chk("restart.mask", pending_mask, 32'h210);
    chk("restart.ready", 32'(mdu_ready), 0);
    // async reset mid-stall with two entries queued
    #1 rst = 1'b1;
    #1;
    chk("arst.ready", 32'(mdu_ready), 0);
    chk("arst.stall", 32'(stall_req), 0);
    chk("arst.mask", pending_mask, 0);
    port("arst", 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    // x0 handling
    cyc(0, 0, 0, 1, 4, 32'h44);
    cyc(1, 0, 32'hDEAD, 0, 0, 0);
    port("x0.wb", 1, 4, 32'h44, 1);
    cyc(1, 0, 32'hDEAD, 1, 0, 32'h55);
    port("x0.idle", 0, 0, 0, 0);
    chk("x0.ready", 32'(mdu_ready), 1);
    cyc(0, 0, 0, 0, 0, 0);
    port("x0.drop", 0, 0, 0, 0);
    chk("x0.mask", pending_mask, 0);
    // simultaneous enqueue and dequeue
    cyc(0, 0, 0, 1, 8, 32'h88);
    cyc(0, 0, 0, 1, 6, 32'h66);
    port("simul.d1", 1, 8, 32'h88, 1);
    chk("simul.ready", 32'(mdu_ready), 1);
    cyc(0, 0, 0, 0, 0, 0);
    port("simul.d2", 1, 6, 32'h66, 1);
    chk("simul.mask", pending_mask, 32'h40);
    cyc(0, 0, 0, 0, 0, 0);
    port("simul.d3", 0, 0, 0, 0);
    // full FIFO rejects a push even while dequeuing
    cyc(1, 3, 32'hCC, 1, 10, 32'hA0);
    cyc(1, 3, 32'hCC, 1, 11, 32'hB0);
    cyc(0, 0, 0, 1, 12, 32'hC0);
    port("fullpop.e2", 1, 10, 32'hA0, 1);
    chk("fullpop.ready", 32'(mdu_ready), 0);
    cyc(0, 0, 0, 0, 0, 0);
    port("fullpop.e3", 1, 11, 32'hB0, 1);
    chk("fullpop.mask", pending_mask, 32'h800);
    cyc(0, 0, 0, 0, 0, 0);
    port("fullpop.e4", 0, 0, 0, 0);
    chk("fullpop.empty", pending_mask, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
